usb_rx_decoder: RTL and testbench

- Upstream neighbour of the receive FIFO in the USB full-speed receive path.
- Samples synchronized D+/D- lines and recovers bit timing from data edges.
- Performs NRZI decode, bit-unstuffing, SYNC detection and EOP detection.
- Assembles LSB-first bytes and writes them into the receive FIFO through its w_enable/w_data/full interface, and flags packet completion and protocol errors to the protocol controller.

---
 rtl/usb_rx_pkg.sv | 15 +
 rtl/usb_rx_bit_timer.sv | 29 ++
 rtl/usb_rx_decoder.sv | 159 +++++++++++++++
 tb/tb_usb_rx_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive decoder.
package usb_rx_pkg;

  typedef enum logic [2:0] {IDLE, SYNC, DATA, EOP, ERR} rx_state_t;

  localparam logic [7:0] SYNC_BYTE   = 8'h80;
  localparam int         STUFF_LIMIT = 6;

  // Line states as {d_plus, d_minus}; 2'b11 is illegal on the bus.
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_ILL = 2'b11;

endpackage

// File: rtl/usb_rx_bit_timer.sv
// Bit-period timer; resynchronises to data edges and strobes at mid-bit.
module usb_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PT    = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic enable,
  input  logic resync,
  output logic sample_strb
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (resync) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == CW'(CLKS_PER_BIT - 1)) ? '0 : count + 1'b1;
    end
  end

  assign sample_strb = enable && (count == CW'(SAMPLE_PT));

endmodule

// File: rtl/usb_rx_decoder.sv
// USB full-speed receive decoder: NRZI decode, unstuffing, SYNC/EOP detection
// and LSB-first byte assembly feeding the receive FIFO.
module usb_rx_decoder
  import usb_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_PT    = 3,
  parameter int MAX_BYTES    = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus_sync,
  input  logic       d_minus_sync,
  input  logic       full,
  output logic       w_enable,
  output logic [7:0] w_data,
  output logic       rcving,
  output logic       rx_done,
  output logic       r_error
);

  localparam int BW = $clog2(MAX_BYTES + 1);

  rx_state_t     state;
  logic          d_plus_prev;
  logic          nrzi_prev;
  logic [2:0]    ones_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift_reg;
  logic [BW-1:0] byte_cnt;
  logic          se0_seen;

  logic       sample_strb;
  logic [1:0] line;
  logic       bit_val;
  logic [7:0] byte_next;

  assign line      = {d_plus_sync, d_minus_sync};
  assign bit_val   = (d_plus_sync == nrzi_prev);
  assign byte_next = {bit_val, shift_reg[7:1]};

  usb_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SAMPLE_PT   (SAMPLE_PT)
  ) u_bit_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .enable     (state != IDLE),
    .resync     (d_plus_sync ^ d_plus_prev),
    .sample_strb(sample_strb)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      d_plus_prev <= 1'b1;
      nrzi_prev   <= 1'b1;
      ones_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      byte_cnt    <= '0;
      se0_seen    <= 1'b0;
      w_enable    <= 1'b0;
      w_data      <= '0;
      rcving      <= 1'b0;
      rx_done     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      w_enable    <= 1'b0;
      rx_done     <= 1'b0;
      d_plus_prev <= d_plus_sync;
      case (state)
        IDLE: begin
          nrzi_prev <= 1'b1;
          ones_cnt  <= '0;
          bit_cnt   <= '0;
          byte_cnt  <= '0;
          se0_seen  <= 1'b0;
          if (d_plus_prev && !d_plus_sync) begin
            state   <= SYNC;
            rcving  <= 1'b1;
            r_error <= 1'b0;
          end
        end
        SYNC, DATA: begin
          if (sample_strb) begin
            if (line == LINE_SE0) begin
              // SE0 is only a clean EOP on a byte boundary after real data.
              if (state == DATA && bit_cnt == 3'd0 && byte_cnt != '0) begin
                state <= EOP;
              end else begin
                state   <= ERR;
                r_error <= 1'b1;
              end
            end else if (line == LINE_ILL) begin
              state   <= ERR;
              r_error <= 1'b1;
            end else begin
              nrzi_prev <= d_plus_sync;
              if (ones_cnt == 3'(STUFF_LIMIT)) begin
                if (bit_val) begin
                  state   <= ERR;
                  r_error <= 1'b1;
                end else begin
                  ones_cnt <= '0;
                end
              end else begin
                ones_cnt  <= bit_val ? ones_cnt + 3'd1 : 3'd0;
                shift_reg <= byte_next;
                bit_cnt   <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  if (state == SYNC) begin
                    if (byte_next == SYNC_BYTE) begin
                      state <= DATA;
                    end else begin
                      state   <= ERR;
                      r_error <= 1'b1;
                    end
                  end else if (full || byte_cnt == BW'(MAX_BYTES)) begin
                    state   <= ERR;
                    r_error <= 1'b1;
                  end else begin
                    w_enable <= 1'b1;
                    w_data   <= byte_next;
                    byte_cnt <= byte_cnt + 1'b1;
                  end
                end
              end
            end
          end
        end
        EOP: begin
          if (sample_strb) begin
            if (line == LINE_J) begin
              rx_done <= 1'b1;
              rcving  <= 1'b0;
              state   <= IDLE;
            end else if (line != LINE_SE0) begin
              state   <= ERR;
              r_error <= 1'b1;
            end
          end
        end
        ERR: begin
          // Leave only after an SE0 sample directly followed by a J sample.
          if (sample_strb) begin
            se0_seen <= (line == LINE_SE0);
            if (line == LINE_J && se0_seen) begin
              rcving <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Self-checking bench: bytes are NRZI/stuff-encoded here and the decoder output
// is compared against the payload the bench itself sent.
module tb_usb_rx_decoder;
  import usb_rx_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       d_plus_sync = 1'b1;
  logic       d_minus_sync = 1'b0;
  logic       full = 1'b0;
  logic       w_enable;
  logic [7:0] w_data;
  logic       rcving;
  logic       rx_done;
  logic       r_error;

  always #5 clk = ~clk;

  usb_rx_decoder dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .d_plus_sync (d_plus_sync),
    .d_minus_sync(d_minus_sync),
    .full        (full),
    .w_enable    (w_enable),
    .w_data      (w_data),
    .rcving      (rcving),
    .rx_done     (rx_done),
    .r_error     (r_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pay[$];
  logic [1:0] sym_q[$];
  bit         raw[$];
  int         exp_done = 0;
  int         got_done = 0;
  int         got_writes = 0;
  int         enc_ones = 0;
  bit         enc_bad_stuff = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Per-cycle monitor: every write must match the next expected byte in order.
  always @(negedge clk) begin
    if (n_rst) begin
      if (w_enable) begin
        got_writes++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got 0x%02h, expected no write", w_data);
        end else begin
          check("write_data", w_data, exp_q.pop_front());
        end
      end
      if (rx_done) begin
        got_done++;
        check("rcving_low_at_done", rcving, 0);
      end
    end
  end

  // Encoder: raw bit stream with a 0 inserted after every six consecutive 1s.
  task automatic push_bit(input bit b);
    raw.push_back(b);
    enc_ones = b ? enc_ones + 1 : 0;
    if (enc_ones == STUFF_LIMIT) begin
      raw.push_back(enc_bad_stuff);
      enc_bad_stuff = 1'b0;
      enc_ones = 0;
    end
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) push_bit(v[i]);
  endtask

  task automatic start_raw(input bit bad_stuff);
    logic [7:0] s;
    raw.delete();
    enc_ones = 0;
    enc_bad_stuff = bad_stuff;
    s = SYNC_BYTE;
    push_byte(s);
  endtask

  // NRZI: a 0 toggles the line, a 1 holds it; idle level is J.
  task automatic encode(input bit with_eop);
    bit level;
    level = 1'b1;
    sym_q.delete();
    foreach (raw[i]) begin
      if (!raw[i]) level = !level;
      sym_q.push_back(level ? LINE_J : LINE_K);
    end
    if (with_eop) begin
      sym_q.push_back(LINE_SE0);
      sym_q.push_back(LINE_SE0);
      sym_q.push_back(LINE_J);
    end
  endtask

  task automatic drive(input bit jitter, input bit tail);
    @(posedge clk);
    #1;
    for (int i = 0; i < sym_q.size(); i++) begin
      {d_plus_sync, d_minus_sync} = sym_q[i];
      repeat ((jitter && (i % 2 == 1)) ? 9 : 8) @(posedge clk);
      #1;
      if (i == 0) begin
        check("sync_start_rcving", rcving, 1);
        check("sync_start_error_clear", r_error, 0);
      end
    end
    if (tail) begin
      {d_plus_sync, d_minus_sync} = LINE_J;
      repeat (24) @(posedge clk);
      #1;
    end
  endtask

  task automatic finish_pkt(input string name, input bit exp_err);
    check({name, "_missing_writes"}, exp_q.size(), 0);
    check({name, "_rx_done_count"}, got_done, exp_done);
    check({name, "_r_error"}, r_error, exp_err);
    check({name, "_rcving_after"}, rcving, 0);
    exp_q.delete();
    got_done = 0;
    exp_done = 0;
  endtask

  // A well-formed packet carrying pay[]; bytes beyond 64 must abort it.
  task automatic run_payload(input string name, input bit jitter);
    start_raw(1'b0);
    foreach (pay[i]) begin
      push_byte(pay[i]);
      if (i < 64) exp_q.push_back(pay[i]);
    end
    encode(1'b1);
    exp_done = (pay.size() <= 64) ? 1 : 0;
    drive(jitter, 1'b1);
    finish_pkt(name, pay.size() > 64);
  endtask

  initial begin
    logic [7:0] p;

    #1;
    check("reset_outputs", {w_enable, w_data, rcving, rx_done, r_error}, 0);
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (4) @(posedge clk);

    // Pin the encoder: SYNC must be KJKJKJKK, and 0xFF after SYNC stuffs at bit 13.
    start_raw(1'b0);
    encode(1'b0);
    for (int i = 0; i < 8; i++) p[i] = sym_q[i][1];
    check("model_sync_dplus", p, 8'b0010_1010);
    push_byte(8'hFF);
    check("model_stuff_len", raw.size(), 17);
    check("model_stuff_bit", raw[13], 0);

    pay = '{8'hA5, 8'h3C};
    run_payload("clean", 1'b0);

    pay = '{8'hFF};
    run_payload("stuff_ok", 1'b0);

    start_raw(1'b1);
    push_byte(8'hFF);
    encode(1'b1);
    exp_done = 0;
    drive(1'b0, 1'b1);
    finish_pkt("stuff_err", 1'b1);

    sym_q = '{LINE_K, LINE_J, LINE_K, LINE_J, LINE_K, LINE_J, LINE_K, LINE_J, LINE_SE0, LINE_J};
    drive(1'b0, 1'b1);
    finish_pkt("bad_sync", 1'b1);

    full = 1'b1;
    start_raw(1'b0);
    push_byte(8'h12);
    encode(1'b1);
    drive(1'b0, 1'b1);
    finish_pkt("fifo_full", 1'b1);
    full = 1'b0;
    pay = '{8'h77};
    run_payload("after_full", 1'b0);

    start_raw(1'b0);
    push_byte(8'h55);
    push_bit(1'b1);
    push_bit(1'b0);
    push_bit(1'b1);
    encode(1'b1);
    exp_q.push_back(8'h55);
    drive(1'b0, 1'b1);
    finish_pkt("bad_eop", 1'b1);

    pay = '{8'hC3, 8'h7E};
    run_payload("jitter", 1'b1);

    for (int k = 0; k < 20; k++) begin
      pay.delete();
      for (int b = 0; b < $urandom_range(1, 6); b++) pay.push_back(8'($urandom));
      run_payload("random", 1'($urandom_range(0, 1)));
    end

    pay.delete();
    for (int b = 0; b < 65; b++) pay.push_back(8'($urandom));
    run_payload("overlong", 1'b0);

    // Reset four data bits into a packet.
    got_writes = 0;
    start_raw(1'b0);
    push_byte(8'h5A);
    encode(1'b0);
    while (sym_q.size() > 12) void'(sym_q.pop_back());
    drive(1'b0, 1'b0);
    check("pre_reset_rcving", rcving, 1);
    #3 n_rst = 1'b0;
    #1;
    check("mid_reset_outputs", {w_enable, w_data, rcving, rx_done, r_error}, 0);
    check("mid_reset_no_write", got_writes, 0);
    {d_plus_sync, d_minus_sync} = LINE_J;
    repeat (3) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_reset_idle", {w_enable, rcving, rx_done, r_error}, 0);
    check("post_reset_no_write", got_writes, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
